// File: rtl/ps2_scan_receiver.sv
// Host-side PS/2 keyboard receiver: synchronizes ps2_clk/ps2_dat, deserializes
// 11-bit frames, checks parity/stop, times out stalled frames and queues codes.
module ps2_scan_receiver #(
    parameter int unsigned FIFO_DEPTH     = 4,
    parameter int unsigned TIMEOUT_CYCLES = 100000
) (
    input  logic       CLOCK_50,
    input  logic       Resetn,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    output logic [7:0] code,
    output logic       code_valid,
    input  logic       code_ack,
    output logic       parity_err,
    output logic       frame_err,
    output logic       overflow,
    input  logic       clear_err,
    output logic       busy
);

    localparam int unsigned AW = $clog2(FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam int unsigned TW = $clog2(TIMEOUT_CYCLES);

    typedef enum logic [1:0] {IDLE, DATA, PARITY, STOP} state_t;

    state_t         state;
    state_t         state_next;
    logic           clk_meta, clk_s, clk_prev;
    logic           dat_meta, dat_s;
    logic           fall;
    logic [2:0]     bit_cnt;
    logic [7:0]     sh;
    logic           par_ok;
    logic [TW-1:0]  tmo_cnt;
    logic           push, perr_set, ferr_set, tmo_hit;
    logic [7:0]     mem [FIFO_DEPTH];
    logic [AW-1:0]  wr_ptr, rd_ptr;
    logic [CW-1:0]  count;
    logic           full, pop, wr_en, ovf_set;

    // Two-flop synchronizers plus one delay stage for falling-edge detection
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            clk_meta <= 1'b1;
            clk_s    <= 1'b1;
            clk_prev <= 1'b1;
            dat_meta <= 1'b1;
            dat_s    <= 1'b1;
        end else begin
            clk_meta <= ps2_clk;
            clk_s    <= clk_meta;
            clk_prev <= clk_s;
            dat_meta <= ps2_dat;
            dat_s    <= dat_meta;
        end
    end

    assign fall = clk_prev & ~clk_s;

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) state <= IDLE;
        else         state <= state_next;
    end

    // One transition per ps2_clk fall; a stall aborts the frame silently
    always_comb begin
        state_next = state;
        push       = 1'b0;
        perr_set   = 1'b0;
        ferr_set   = 1'b0;
        tmo_hit    = 1'b0;
        if (fall) begin
            case (state)
                IDLE:   if (!dat_s) state_next = DATA;
                DATA:   if (bit_cnt == 3'd7) state_next = PARITY;
                PARITY: state_next = STOP;
                STOP: begin
                    state_next = IDLE;
                    if (!dat_s)      ferr_set = 1'b1;
                    else if (par_ok) push     = 1'b1;
                    else             perr_set = 1'b1;
                end
                default: state_next = IDLE;
            endcase
        end else if (state != IDLE && tmo_cnt == TW'(TIMEOUT_CYCLES - 1)) begin
            state_next = IDLE;
            tmo_hit    = 1'b1;
        end
    end

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            bit_cnt <= 3'd0;
            sh      <= 8'd0;
            par_ok  <= 1'b0;
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= (fall || state == IDLE) ? '0 : tmo_cnt + TW'(1);
            if (fall) begin
                case (state)
                    IDLE:   bit_cnt <= 3'd0;
                    DATA: begin
                        sh      <= {dat_s, sh[7:1]};
                        bit_cnt <= bit_cnt + 3'd1;
                    end
                    PARITY: par_ok <= (^sh) ^ dat_s;
                    default: ;
                endcase
            end else if (tmo_hit) begin
                sh <= 8'd0;
            end
        end
    end

    // A pop frees the slot in the same cycle, so a push into a full FIFO still lands
    assign pop     = code_ack & code_valid;
    assign full    = (count == CW'(FIFO_DEPTH));
    assign wr_en   = push & (~full | pop);
    assign ovf_set = push & full & ~pop;

    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            for (int i = 0; i < int'(FIFO_DEPTH); i++) mem[i] <= 8'd0;
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_en) begin
                mem[wr_ptr] <= sh;
                wr_ptr      <= wr_ptr + AW'(1);
            end
            if (pop) rd_ptr <= rd_ptr + AW'(1);
            case ({wr_en, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: ;
            endcase
        end
    end

    assign code       = mem[rd_ptr];
    assign code_valid = (count != '0);
    assign busy       = (state != IDLE);

    // Sticky error flags; a set event outranks clear_err
    always_ff @(posedge CLOCK_50 or negedge Resetn) begin
        if (!Resetn) begin
            parity_err <= 1'b0;
            frame_err  <= 1'b0;
            overflow   <= 1'b0;
        end else begin
            if (perr_set)       parity_err <= 1'b1;
            else if (clear_err) parity_err <= 1'b0;
            if (ferr_set)       frame_err  <= 1'b1;
            else if (clear_err) frame_err  <= 1'b0;
            if (ovf_set)        overflow   <= 1'b1;
            else if (clear_err) overflow   <= 1'b0;
        end
    end

endmodule

// File: tb/tb_ps2_scan_receiver.sv
// Directed bench for ps2_scan_receiver: a keyboard model drives frames on a
// scaled PS/2 clock and the outputs are compared against hand-computed values.
module tb_ps2_scan_receiver;

    localparam int unsigned HALF    = 20;   // system cycles per PS/2 clock phase
    localparam int unsigned TMO     = 200;  // scaled timeout, well above one bit period
    localparam int unsigned STALL   = 300;  // idle gap longer than TMO

    logic       clk;
    logic       rst_n;
    logic       ps2_clk;
    logic       ps2_dat;
    logic [7:0] code;
    logic       code_valid;
    logic       code_ack;
    logic       parity_err;
    logic       frame_err;
    logic       overflow;
    logic       clear_err;
    logic       busy;

    int n_checks = 0;
    int n_pass   = 0;

    ps2_scan_receiver #(.FIFO_DEPTH(4), .TIMEOUT_CYCLES(TMO)) dut (
        .CLOCK_50   (clk),
        .Resetn     (rst_n),
        .ps2_clk    (ps2_clk),
        .ps2_dat    (ps2_dat),
        .code       (code),
        .code_valid (code_valid),
        .code_ack   (code_ack),
        .parity_err (parity_err),
        .frame_err  (frame_err),
        .overflow   (overflow),
        .clear_err  (clear_err),
        .busy       (busy)
    );

    initial clk = 1'b0;
    always #10 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    endtask

    task automatic ps2_bit(input logic b);
        @(negedge clk);
        ps2_dat = b;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b0;
        repeat (HALF) @(negedge clk);
        ps2_clk = 1'b1;
    endtask

    // Full frame: start, 8 data LSB first, odd parity (optionally flipped), stop
    task automatic send_frame(input logic [7:0] data, input logic bad_par, input logic stop);
        ps2_bit(1'b0);
        for (int i = 0; i < 8; i++) ps2_bit(data[i]);
        ps2_bit(~(^data) ^ bad_par);
        ps2_bit(stop);
        ps2_dat = 1'b1;
        repeat (10) @(negedge clk);
    endtask

    task automatic partial(input int nbits);
        ps2_bit(1'b0);
        for (int i = 0; i < nbits; i++) ps2_bit(i[0]);
        ps2_dat = 1'b1;
        repeat (5) @(negedge clk);
    endtask

    task automatic ack();
        @(negedge clk);
        code_ack = 1'b1;
        @(negedge clk);
        code_ack = 1'b0;
    endtask

    task automatic clr();
        @(negedge clk);
        clear_err = 1'b1;
        @(negedge clk);
        clear_err = 1'b0;
    endtask

    task automatic check_flags(input string tag, input logic [2:0] exp);
        @(negedge clk);
        check(tag, {29'd0, parity_err, frame_err, overflow}, {29'd0, exp});
    endtask

    logic [7:0] burst [5];

    initial begin
        burst[0] = 8'h16; burst[1] = 8'h1E; burst[2] = 8'h26;
        burst[3] = 8'h25; burst[4] = 8'h2E;
        rst_n     = 1'b0;
        ps2_clk   = 1'b1;
        ps2_dat   = 1'b1;
        code_ack  = 1'b0;
        clear_err = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_valid", 32'(code_valid), 32'd0);
        check("reset_busy",  32'(busy), 32'd0);
        check("reset_code",  32'(code), 32'd0);
        check_flags("reset_flags", 3'b000);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);

        // Single good frame; busy seen mid-frame
        fork
            send_frame(8'h1C, 1'b0, 1'b1);
            begin
                repeat (3 * 2 * HALF) @(negedge clk);
                check("t1_busy_mid", 32'(busy), 32'd1);
            end
        join
        check("t1_valid", 32'(code_valid), 32'd1);
        check("t1_code",  32'(code), 32'h1C);
        check("t1_busy",  32'(busy), 32'd0);
        check_flags("t1_flags", 3'b000);
        ack();
        check("t1_empty", 32'(code_valid), 32'd0);

        // Bad parity
        send_frame(8'h1C, 1'b1, 1'b1);
        check("t2_valid", 32'(code_valid), 32'd0);
        check_flags("t2_perr", 3'b100);
        clr();
        check_flags("t2_clear", 3'b000);

        // Ordering across two frames
        send_frame(8'hF0, 1'b0, 1'b1);
        send_frame(8'h1C, 1'b0, 1'b1);
        check("t3_head0", 32'(code), 32'hF0);
        ack();
        check("t3_head1", 32'(code), 32'h1C);
        check("t3_valid1", 32'(code_valid), 32'd1);
        ack();
        check("t3_empty", 32'(code_valid), 32'd0);

        // Overflow: fifth code is dropped
        for (int i = 0; i < 5; i++) send_frame(burst[i], 1'b0, 1'b1);
        check_flags("t4_ovf", 3'b001);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("t4_pop%0d", i), 32'(code), 32'(burst[i]));
            ack();
        end
        check("t4_empty", 32'(code_valid), 32'd0);
        clr();
        check_flags("t4_clear", 3'b000);

        // Stalled frame times out silently
        partial(4);
        check("t5_busy_stall", 32'(busy), 32'd1);
        repeat (STALL) @(negedge clk);
        check("t5_busy_tmo", 32'(busy), 32'd0);
        send_frame(8'h29, 1'b0, 1'b1);
        check("t5_code", 32'(code), 32'h29);
        check_flags("t5_flags", 3'b000);
        ack();
        check("t5_empty", 32'(code_valid), 32'd0);

        // Reset mid-frame drops the partial frame and queued codes
        send_frame(8'h11, 1'b0, 1'b1);
        check("t6_pre", 32'(code_valid), 32'd1);
        partial(5);
        rst_n = 1'b0;
        repeat (3) @(negedge clk);
        check("t6_rst_valid", 32'(code_valid), 32'd0);
        check("t6_rst_busy",  32'(busy), 32'd0);
        rst_n = 1'b1;
        repeat (5) @(negedge clk);
        send_frame(8'h5A, 1'b0, 1'b1);
        check("t6_code", 32'(code), 32'h5A);
        ack();
        check("t6_empty", 32'(code_valid), 32'd0);

        // Stop bit 0 is a framing error
        send_frame(8'h33, 1'b0, 1'b0);
        check("t7_valid", 32'(code_valid), 32'd0);
        check_flags("t7_ferr", 3'b010);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
